// File: rtl/fp13_to_s8_seq_if.sv
// Handshake and data bundle for the fp13 -> s8 sequential converter.
//   start : conversion request, sampled only while ready=1
//   fp13  : {sign, exp[3:0], frac[7:0]}, captured on the accepting edge
//   ready : converter idle, able to accept
//   busy  : conversion in progress (shifting or done cycle)
//   done  : single-cycle pulse, s8/ovf valid from this cycle on
//   s8    : {sign, mag[6:0]}, held until the next done
//   ovf   : result saturated to magnitude 127, held with s8
interface fp13_to_s8_seq_if;
    logic        start;
    logic [12:0] fp13;
    logic        ready;
    logic        busy;
    logic        done;
    logic [7:0]  s8;
    logic        ovf;

    modport master (output start, fp13, input ready, busy, done, s8, ovf);
    modport slave  (input start, fp13, output ready, busy, done, s8, ovf);
endinterface

// File: rtl/fp13_to_s8_seq.sv
// Sequential fp13 -> sign-magnitude s8 converter.
// Value = 0.frac * 2^exp; the magnitude is recovered by shifting frac right
// (8 - exp) times, one bit per clock.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; aborts any conversion without done
//   bus   : slave side of fp13_to_s8_seq_if (start/fp13 in; ready/busy/
//           done/s8/ovf out)
// ROUND = 0 truncates; ROUND = 1 rounds half up on the last bit shifted out,
// saturating at 127.
module fp13_to_s8_seq #(
    parameter bit ROUND = 1'b0
) (
    input logic               clk,
    input logic               reset,
    fp13_to_s8_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [7:0]  frac;
    logic [2:0]  cnt;
    logic        sign;
    logic [7:0]  s8;
    logic        ovf;
    logic        done;

    logic [3:0]  in_exp;
    logic [6:0]  res_mag;
    logic        res_ovf;
    logic        res_sign;
    logic [7:0]  sum;

    assign in_exp = bus.fp13[11:8];

    // Result as it will be after the final shift: the magnitude is frac[7:1]
    // and the guard (last bit shifted out) is frac[0], so no separate guard
    // register is needed to form the registered result.
    always_comb begin
        res_mag = frac[7:1];
        res_ovf = 1'b0;
        sum     = {1'b0, frac[7:1]} + {7'b0, (ROUND && frac[0])};
        if (sum[7]) begin
            res_mag = 7'h7F;
            res_ovf = 1'b1;
        end else begin
            res_mag = sum[6:0];
        end
        // no negative zero
        res_sign = sign && (res_mag != 7'h00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            frac  <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
            s8    <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        sign <= bus.fp13[12];
                        frac <= bus.fp13[7:0];
                        if (in_exp == 4'd0) begin
                            s8    <= '0;
                            ovf   <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (in_exp > 4'd7) begin
                            s8    <= {bus.fp13[12], 7'h7F};
                            ovf   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt   <= 3'(4'd8 - in_exp);
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    frac <= frac >> 1;
                    cnt  <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        s8    <= {res_sign, res_mag};
                        ovf   <= res_ovf;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state == SHIFT) || (state == DONE);
    assign bus.done  = done;
    assign bus.s8    = s8;
    assign bus.ovf   = ovf;
endmodule

// File: tb/tb_fp13_to_s8_seq.sv
module tb_fp13_to_s8_seq;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    fp13_to_s8_seq_if bus0 ();
    fp13_to_s8_seq_if bus1 ();

    fp13_to_s8_seq #(.ROUND(1'b0)) dut_r0 (.clk(clk), .reset(reset), .bus(bus0));
    fp13_to_s8_seq #(.ROUND(1'b1)) dut_r1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic st, input logic [12:0] v);
        bus0.start = st;
        bus1.start = st;
        bus0.fp13  = v;
        bus1.fp13  = v;
    endtask

    // Start a conversion at a negedge, accept on the next posedge, then
    // count negedges until done (bounded). Checks latency, pulse width and
    // both result variants.
    task automatic run(input string tag, input logic [12:0] v,
                       input logic [7:0] s8_r0, input logic ovf_r0,
                       input logic [7:0] s8_r1, input logic ovf_r1,
                       input int lat);
        int n;
        @(negedge clk);
        drive(1'b1, v);
        @(negedge clk);
        drive(1'b0, 13'h1FFF);   // changes while busy must have no effect
        n = 1;
        while (!bus0.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_done1"}, {31'b0, bus1.done}, 1);
        chk({tag, "_s8_r0"}, {24'b0, bus0.s8}, {24'b0, s8_r0});
        chk({tag, "_ovf_r0"}, {31'b0, bus0.ovf}, {31'b0, ovf_r0});
        chk({tag, "_s8_r1"}, {24'b0, bus1.s8}, {24'b0, s8_r1});
        chk({tag, "_ovf_r1"}, {31'b0, bus1.ovf}, {31'b0, ovf_r1});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, bus0.done}, 0);
        chk({tag, "_ready"}, {31'b0, bus0.ready}, 1);
        chk({tag, "_hold"}, {24'b0, bus0.s8}, {24'b0, s8_r0});
    endtask

    initial begin
        int dones;
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        drive(1'b0, 13'h0000);
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_s8", {24'b0, bus0.s8}, 0);
        chk("rst_ovf", {31'b0, bus0.ovf}, 0);
        chk("rst_ready", {31'b0, bus0.ready}, 1);
        chk("rst_busy", {31'b0, bus0.busy}, 0);
        chk("rst_done", {31'b0, bus0.done}, 0);

        // reset has priority over start
        drive(1'b1, 13'h03A0);
        @(negedge clk);
        chk("rst_start_ready", {31'b0, bus0.ready}, 1);
        chk("rst_start_busy", {31'b0, bus0.busy}, 0);
        drive(1'b0, 13'h0000);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'b0, bus0.ready}, 1);

        // directed conversions: tag, input, r0 result, r1 result, latency
        run("exp3",   13'h03A0, 8'h05, 1'b0, 8'h05, 1'b0, 6);
        run("neg7",   13'h17FE, 8'hFF, 1'b0, 8'hFF, 1'b0, 2);
        run("negz",   13'h1000, 8'h00, 1'b0, 8'h00, 1'b0, 1);
        run("exp9",   13'h0980, 8'h7F, 1'b1, 8'h7F, 1'b1, 1);
        run("ovfclr", 13'h0140, 8'h00, 1'b0, 8'h01, 1'b0, 8);
        run("half",   13'h01C0, 8'h01, 1'b0, 8'h02, 1'b0, 8);
        run("sat",    13'h07FF, 8'h7F, 1'b0, 8'h7F, 1'b1, 2);

        // start pulsed during SHIFT is ignored
        @(negedge clk);
        drive(1'b1, 13'h0180);
        @(negedge clk);
        drive(1'b0, 13'h0000);
        chk("ign_busy", {31'b0, bus0.busy}, 1);
        @(negedge clk);
        drive(1'b1, 13'h0080);
        @(negedge clk);
        drive(1'b0, 13'h0000);
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus0.done) begin
                dones++;
                chk("ign_s8", {24'b0, bus0.s8}, 32'h01);
            end
            @(negedge clk);
        end
        chk("ign_dones", dones, 1);
        chk("ign_final", {24'b0, bus0.s8}, 32'h01);

        // reset mid-SHIFT aborts without done
        drive(1'b1, 13'h0180);
        @(negedge clk);
        drive(1'b0, 13'h0000);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", {31'b0, bus0.busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", {31'b0, bus0.ready}, 1);
        chk("abort_s8", {24'b0, bus0.s8}, 0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus0.done) dones++;
            @(negedge clk);
        end
        chk("abort_dones", dones, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
